dmem_ctrl: RTL
==============

# dmem_ctrl

Parametrised data-memory controller for the pipelined RISC-V core. It replaces the plain single-cycle word data memory with:
- byte, halfword and word access, with sign or zero extension on loads;
- a configurable depth;
- a programmable number of wait states, reported to the pipeline through a `stall` handshake.

It sits on the core's Memory stage. Its inputs are the M-stage address, store data and access controls; its outputs are the load data and a stall signal for the hazard unit.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥4.
- `WAIT`, 0: wait states per access, 0..15.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: M stage holds a load or store.
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned.
- `size` input 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `unsigned_ld` input 1: zero-extend loads (LBU/LHU).
- `rdata` output 32: load data, extended, valid while `done`.
- `stall` output 1: freeze the pipeline this cycle.
- `done` output 1: the access completes at the next rising edge.
- `misalign` output 1: the completing access is misaligned (see Configuration).

## Operation
- Storage is an array of DEPTH × 32 bits and is not cleared by reset.
- Word index is `addr[AW+1:2]`, where AW = log2(DEPTH). Upper address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
- Memory is little-endian: lane k is data bits [8k+7:8k].
- Stores:
  - byte: writes `wdata[7:0]` to lane `addr[1:0]`;
  - half: writes `wdata[15:0]` to lanes {`addr[1]`·2, +1};
  - word: writes all four lanes.
- Loads:
  - read is combinational from the array;
  - the selected lane(s) are extended to 32 bits using `unsigned_ld`; word loads ignore `unsigned_ld`.
- FSM states are IDLE and BUSY, with a 4-bit counter `cnt`:
  - IDLE, `req`=1, WAIT=0: `done`=1, `stall`=0. The access completes at this edge and the FSM stays in IDLE.
  - IDLE, `req`=1, WAIT>0: the request is accepted. `addr`, `we`, `wdata`, `size` and `unsigned_ld` are captured, `cnt`←WAIT−1, state becomes BUSY, and `stall`=1.
  - BUSY, `req`=1, `cnt`≠0: `stall`=1 and `cnt` decrements.
  - BUSY, `req`=1, `cnt`=0: `done`=1 and `stall`=0. The access uses the captured values and completes at this edge; the next state is IDLE.
  - BUSY, `req`=0: the access is aborted. No write occurs and the next state is IDLE.
- Input changes after acceptance are ignored until the access completes.
- In IDLE with `req`=0, `stall`=0 and `done`=0.
- `rdata` is 0 whenever `done`=0 or `we`=1.

## Timing
- Each access occupies WAIT+1 cycles, with `stall` high for exactly WAIT of them.
- Back-to-back requests: a new request is accepted in IDLE on the cycle after completion, with no bubble beyond the WAIT cycles.
- `stall`, `done`, `rdata` and `misalign` are combinational from state and inputs.
- Store writes occur on the completing rising edge.
- Reset asserted, including mid-BUSY:
  - state→IDLE, `cnt`→0, captured registers→0;
  - no write occurs;
  - `stall`=0, `done`=0, `misalign`=0, `rdata`=0 while `reset` is low.
- `req` asserted at reset release is accepted on the first rising edge after release.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - an access is misaligned if it is a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0;
  - on the completing cycle of a misaligned access, `misalign`=1, stores are suppressed and `rdata`=0;
  - timing is unchanged.
- Undefined:
  - `misalign` is tied to 0;
  - half accesses clear `addr[0]`, word accesses clear `addr[1:0]`, and the access proceeds.

## Test plan
- WAIT=2: store word 0xDEADBEEF to 0x10. Require `stall`=1 for 2 cycles, then `done`=1 for 1 cycle. A following word load of 0x10 returns 0xDEADBEEF.
- Byte loads after the first test:
  - 0x13 signed returns 0xFFFFFFDE;
  - 0x13 unsigned returns 0x000000DE;
  - 0x10 returns 0xFFFFFFEF.
- Store half 0x1234 to 0x12, then load word 0x10: returns 0x1234BEEF.
- Wrap: with DEPTH=256, store 0xCAFEF00D to 0x400. A load from 0x000 returns 0xCAFEF00D.
- WAIT=3: pull `reset` low during the second BUSY cycle of a store to 0x20. Require no write (old value intact) and `stall`=0 immediately.
- Misalignment, word store 0x55 to 0x21:
  - with the macro: `misalign`=1 on the done cycle and memory is unchanged;
  - without the macro: 0x00000055 is written to 0x20.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the Memory stage of the pipelined RISC-V core.
// Supports byte/half/word access with sign or zero extension, DEPTH words of storage,
// and WAIT programmable wait states signalled to the hazard unit through stall/done.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flag and suppress misaligned accesses
// instead of silently aligning them).
module dmem_ctrl #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT > 0) ? (WAIT - 1) : 0);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          accept;

    logic [AW+1:0] cap_addr;
    logic          cap_we;
    logic [31:0]   cap_wdata;
    logic [1:0]    cap_size;
    logic          cap_unsigned;

    logic [AW+1:0] acc_addr_raw;
    logic [AW+1:0] acc_addr;
    logic          acc_we;
    logic [31:0]   acc_wdata;
    logic [1:0]    acc_size;
    logic          acc_unsigned;
    logic          acc_mis;

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shifted;
    logic [31:0]   ld_ext;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic          do_write;

    logic [31:0]   mem [DEPTH];

    // Upper address bits are deliberately ignored so addresses wrap modulo 4*DEPTH.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // State register, wait counter and capture of the accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_addr     <= '0;
            cap_we       <= 1'b0;
            cap_wdata    <= 32'd0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_addr     <= addr[AW+1:0];
                cap_we       <= we;
                cap_wdata    <= wdata;
                cap_size     <= size;
                cap_unsigned <= unsigned_ld;
            end
        end
    end

    // Next-state logic plus the stall/done handshake; a dropped req in BUSY aborts.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        if (reset && req) begin
            case (state)
                IDLE: begin
                    if (WAIT == 0) begin
                        done = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        accept     = 1'b1;
                        state_next = BUSY;
                        cnt_next   = WAIT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stall    = 1'b1;
                        cnt_next = cnt - 4'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state == BUSY) begin
            state_next = IDLE;
        end
    end

    // Select live inputs in IDLE or the captured request in BUSY, then align or flag it.
    always_comb begin
        acc_addr_raw = (state == BUSY) ? cap_addr     : addr[AW+1:0];
        acc_we       = (state == BUSY) ? cap_we       : we;
        acc_wdata    = (state == BUSY) ? cap_wdata    : wdata;
        acc_size     = (state == BUSY) ? cap_size     : size;
        acc_unsigned = (state == BUSY) ? cap_unsigned : unsigned_ld;
        acc_addr     = acc_addr_raw;
        acc_mis      = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        acc_mis = ((acc_size == 2'b01) && acc_addr_raw[0]) ||
                  (acc_size[1] && (acc_addr_raw[1:0] != 2'b00));
`else
        if (acc_size == 2'b01) begin
            acc_addr[0] = 1'b0;
        end else if (acc_size[1]) begin
            acc_addr[1:0] = 2'b00;
        end
`endif
    end

    // Combinational read, lane extraction and sign/zero extension of load data.
    always_comb begin
        word_idx   = acc_addr[AW+1:2];
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> {acc_addr[1:0], 3'b000};
        case (acc_size)
            2'b00:   ld_ext = acc_unsigned ? {24'd0, rd_shifted[7:0]}
                                           : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   ld_ext = acc_unsigned ? {16'd0, rd_shifted[15:0]}
                                           : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_ext = rd_word;
        endcase
        rdata    = (done && !acc_we && !acc_mis) ? ld_ext : 32'd0;
        misalign = done && acc_mis;
    end

    // Byte-lane enables and replicated store data for the completing store.
    always_comb begin
        case (acc_size)
            2'b00: begin
                lane_en   = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = acc_wdata;
            end
        endcase
        do_write = done && acc_we && !acc_mis;
    end

    // Storage array, written on the completing edge only; never cleared by reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
                end
            end
        end
    end

endmodule
